// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the read, write and scoreboard-allocation signals of the
//   multi-port register file into one interface.
//
//   master : issue/writeback side (drives requests, receives read results)
//   slave  : the register file itself
//
//   Signals
//     rd_en      [NRD]          read enable per read port
//     rd_addr    [NRD*ADDR_W]   read address, port i at [i*ADDR_W +: ADDR_W]
//     rd_data    [NRD*XLEN]     registered read data, port i at [i*XLEN +: XLEN]
//     rd_busy    [NRD]          registered busy flag of the register read
//     wr_en      [NWR]          write enable per write port
//     wr_addr    [NWR*ADDR_W]   write address
//     wr_data    [NWR*XLEN]     write data
//     alloc_en                  mark alloc_addr busy
//     alloc_addr [ADDR_W]       register to mark busy
//     any_busy                  registered OR of all busy bits
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*XLEN-1:0]   wr_data;
  logic                  alloc_en;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  any_busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port integer register file with a per-register busy
//   scoreboard. NRD registered read ports (1-cycle latency), NWR write ports
//   with same-cycle write-to-read forwarding. Issue marks destination
//   registers busy through alloc; writeback clears them by writing.
//
//   Ports
//     clk   clock, all state updates on the rising edge
//     rst   asynchronous reset, active low; clears data, busy and outputs
//     bus   regfile_mp_if.slave carrying the read/write/alloc signals
//
//   Parameters
//     XLEN, NUM_REGS, NRD, NWR must match the connected interface instance.
//     ZERO_REG=1 makes register 0 read as zero and never become busy.
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  // One extra bit so the depth itself is representable for range checks
  // when NUM_REGS is a power of two.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_REGS);

  // -------------------------------------------------------------------------
  // Address qualification: an address takes part in writes, allocs and
  // reads only if it is inside the array and is not the hardwired zero reg.
  // -------------------------------------------------------------------------
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [ADDR_W-1:0] rd_addr_a [NRD];
  logic [ADDR_W-1:0] wr_addr_a [NWR];
  logic [XLEN-1:0]   wr_data_a [NWR];
  logic [NWR-1:0]    wr_ok;
  logic [NRD-1:0]    rd_ok;
  logic              alloc_ok;

  // Architectural state
  logic [XLEN-1:0]     regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_cleared;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] clear_mask;
  logic [NUM_REGS-1:0] set_mask;

  // Read path
  logic [XLEN-1:0] rd_val       [NRD];
  logic [NRD-1:0]  rd_bsy;
  logic [XLEN-1:0] rd_data_reg  [NRD];
  logic [NRD-1:0]  rd_busy_reg;
  logic            any_busy_reg;

  // -------------------------------------------------------------------------
  // Unpack flat buses into per-port arrays
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr_port
      assign wr_addr_a[gi] = bus.wr_addr[gi*ADDR_W +: ADDR_W];
      assign wr_data_a[gi] = bus.wr_data[gi*XLEN +: XLEN];
      assign wr_ok[gi]     = bus.wr_en[gi] && addr_ok(wr_addr_a[gi]);
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd_port
      assign rd_addr_a[gi]                  = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign rd_ok[gi]                      = addr_ok(rd_addr_a[gi]);
      assign bus.rd_data[gi*XLEN +: XLEN]   = rd_data_reg[gi];
    end
  endgenerate

  assign alloc_ok     = bus.alloc_en && addr_ok(bus.alloc_addr);
  assign bus.rd_busy  = rd_busy_reg;
  assign bus.any_busy = any_busy_reg;

  // -------------------------------------------------------------------------
  // Scoreboard next state. Clears from writes are applied first, then the
  // alloc set, so an alloc racing a write to the same register leaves it
  // busy for the new producer.
  // -------------------------------------------------------------------------
  always_comb begin
    clear_mask = '0;
    set_mask   = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) begin
        clear_mask[wr_addr_a[j]] = 1'b1;
      end
    end
    if (alloc_ok) begin
      set_mask[bus.alloc_addr] = 1'b1;
    end
    busy_cleared = busy_reg & ~clear_mask;
    busy_next    = busy_cleared | set_mask;
  end

  // -------------------------------------------------------------------------
  // Read lookup with forwarding. Later write ports override earlier ones,
  // matching the write priority of the storage array. The busy flag seen by
  // a read reflects this cycle's clears but not this cycle's alloc, so it
  // agrees with the forwarded data.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_val[i] = '0;
      rd_bsy[i] = 1'b0;
      if (rd_ok[i]) begin
        rd_val[i] = regs_reg[rd_addr_a[i]];
        rd_bsy[i] = busy_cleared[rd_addr_a[i]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (wr_addr_a[j] == rd_addr_a[i])) begin
            rd_val[i] = wr_data_a[j];
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register storage. Loop order makes the highest write port win when
  // several ports target the same register in one cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_reg[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) begin
          regs_reg[wr_addr_a[j]] <= wr_data_a[j];
        end
      end
    end
  end

  // Scoreboard and summary flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg     <= '0;
      any_busy_reg <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      any_busy_reg <= |busy_next;
    end
  end

  // Read output registers hold their value while the port is disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NRD; i++) begin
        rd_data_reg[i] <= '0;
      end
      rd_busy_reg <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (bus.rd_en[i]) begin
          rd_data_reg[i] <= rd_val[i];
          rd_busy_reg[i] <= rd_bsy[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp: hand-derived vector table for the
//   directed scenarios, an asynchronous mid-operation reset sequence, and a
//   randomized phase compared against an architectural reference model.
// ---------------------------------------------------------------------------
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(
    .XLEN(XLEN), .NUM_REGS(NREG), .NRD(2), .NWR(2), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural registers, busy bits, expected outputs
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  logic [XLEN-1:0] m_d    [2];
  logic            m_b    [2];
  logic            m_any;

  typedef struct {
    logic [1:0]      re;
    logic [AW-1:0]   ra0, ra1;
    logic [1:0]      we;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            al;
    logic [AW-1:0]   aa;
    logic [XLEN-1:0] ed0, ed1;
    logic [1:0]      eb;
    logic            ea;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_d[0] = '0; m_d[1] = '0;
    m_b[0] = 1'b0; m_b[1] = 1'b0;
    m_any = 1'b0;
  endtask

  // Architectural effect of one clock edge, stated in terms of the rules:
  // reads observe the post-write value (highest port wins) and the busy bit
  // after write clears but before alloc; register 0 is always zero / idle.
  task automatic model_step(input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                            input logic [1:0] we, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                            input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                            input logic al, input logic [AW-1:0] aa);
    logic [AW-1:0]   ra [2];
    logic [AW-1:0]   wa [2];
    logic [XLEN-1:0] wd [2];
    ra[0] = ra0; ra[1] = ra1;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    for (int i = 0; i < 2; i++) begin
      if (re[i]) begin
        if (ra[i] == 0) begin
          m_d[i] = '0;
          m_b[i] = 1'b0;
        end else begin
          logic written;
          written = 1'b0;
          m_d[i]  = m_regs[ra[i]];
          for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] == ra[i]) begin
              m_d[i]  = wd[j];
              written = 1'b1;
            end
          end
          m_b[i] = m_busy[ra[i]] && !written;
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (we[j] && wa[j] != 0) begin
        m_regs[wa[j]] = wd[j];
        m_busy[wa[j]] = 1'b0;
      end
    end
    if (al && aa != 0) m_busy[aa] = 1'b1;
    m_any = 1'b0;
    for (int r = 0; r < NREG; r++) m_any = m_any | m_busy[r];
  endtask

  // Drive one transaction, advance one edge, compare against the model
  task automatic step(input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic [1:0] we, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                      input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                      input logic al, input logic [AW-1:0] aa, input string tag);
    bus.rd_en      = re;
    bus.rd_addr    = {ra1, ra0};
    bus.wr_en      = we;
    bus.wr_addr    = {wa1, wa0};
    bus.wr_data    = {wd1, wd0};
    bus.alloc_en   = al;
    bus.alloc_addr = aa;
    model_step(re, ra0, ra1, we, wa0, wd0, wa1, wd1, al, aa);
    @(posedge clk);
    #1;
    chk({tag, " model rd_data0"}, bus.rd_data[0 +: XLEN], m_d[0]);
    chk({tag, " model rd_data1"}, bus.rd_data[XLEN +: XLEN], m_d[1]);
    chk({tag, " model rd_busy"}, 64'(bus.rd_busy), 64'({m_b[1], m_b[0]}));
    chk({tag, " model any_busy"}, 64'(bus.any_busy), 64'(m_any));
    $display("[TB] %s re=%b ra=%0d/%0d we=%b wa=%0d/%0d al=%b aa=%0d -> rd=%h/%h busy=%b any=%b",
             tag, re, ra0, ra1, we, wa0, wa1, al, aa,
             bus.rd_data[0 +: XLEN], bus.rd_data[XLEN +: XLEN], bus.rd_busy, bus.any_busy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_data0"}, bus.rd_data[0 +: XLEN], '0);
    chk({tag, " rd_data1"}, bus.rd_data[XLEN +: XLEN], '0);
    chk({tag, " rd_busy"}, 64'(bus.rd_busy), '0);
    chk({tag, " any_busy"}, 64'(bus.any_busy), '0);
  endtask

  initial begin
    // Directed vectors: inputs and hand-derived outputs after the edge
    //          re    ra0   ra1   we    wa0   wd0              wa1   wd1       al    aa     ed0              ed1              eb     ea
    tbl[0]  = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 64'hDEAD_BEEF,   5'd0, 64'h0,    1'b0, 5'd0,  64'h0,           64'h0,           2'b00, 1'b0};
    tbl[1]  = '{2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b0, 5'd0,  64'hDEAD_BEEF,   64'hDEAD_BEEF,   2'b00, 1'b0};
    tbl[2]  = '{2'b11, 5'd7, 5'd5, 2'b01, 5'd7, 64'h1234,        5'd0, 64'h0,    1'b0, 5'd0,  64'h1234,        64'hDEAD_BEEF,   2'b00, 1'b0};
    tbl[3]  = '{2'b11, 5'd9, 5'd9, 2'b11, 5'd9, 64'hAAAA,        5'd9, 64'h5555, 1'b0, 5'd0,  64'h5555,        64'h5555,        2'b00, 1'b0};
    tbl[4]  = '{2'b11, 5'd9, 5'd7, 2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b0, 5'd0,  64'h5555,        64'h1234,        2'b00, 1'b0};
    tbl[5]  = '{2'b11, 5'd0, 5'd0, 2'b01, 5'd0, 64'hFFFF,        5'd0, 64'h0,    1'b1, 5'd0,  64'h0,           64'h0,           2'b00, 1'b0};
    tbl[6]  = '{2'b10, 5'd0, 5'd5, 2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b0, 5'd0,  64'h0,           64'hDEAD_BEEF,   2'b00, 1'b0};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b1, 5'd3,  64'h0,           64'hDEAD_BEEF,   2'b00, 1'b1};
    tbl[8]  = '{2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b0, 5'd0,  64'h0,           64'hDEAD_BEEF,   2'b01, 1'b1};
    tbl[9]  = '{2'b11, 5'd3, 5'd3, 2'b10, 5'd0, 64'h0,           5'd3, 64'h33,   1'b1, 5'd3,  64'h33,          64'h33,          2'b00, 1'b1};
    tbl[10] = '{2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b0, 5'd0,  64'h33,          64'h33,          2'b11, 1'b1};
    tbl[11] = '{2'b01, 5'd3, 5'd0, 2'b01, 5'd3, 64'h44,          5'd0, 64'h0,    1'b0, 5'd0,  64'h44,          64'h33,          2'b10, 1'b0};
    tbl[12] = '{2'b10, 5'd0, 5'd12,2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b1, 5'd12, 64'h44,          64'h0,           2'b00, 1'b1};
    tbl[13] = '{2'b11, 5'd12,5'd12,2'b00, 5'd0, 64'h0,           5'd0, 64'h0,    1'b1, 5'd12, 64'h0,           64'h0,           2'b11, 1'b1};
    tbl[14] = '{2'b11, 5'd12,5'd9, 2'b11, 5'd12,64'h1,           5'd12,64'h2,    1'b0, 5'd0,  64'h2,           64'h5555,        2'b00, 1'b0};

    bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.alloc_en = 1'b0; bus.alloc_addr = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Every register reads zero and idle after reset
    for (int k = 0; k < NREG / 2; k++) begin
      step(2'b11, AW'(2 * k), AW'(2 * k + 1), 2'b00, '0, '0, '0, '0, 1'b0, '0, "readall");
      chk("readall rd_data0", bus.rd_data[0 +: XLEN], '0);
      chk("readall rd_data1", bus.rd_data[XLEN +: XLEN], '0);
    end

    // Directed table
    for (int v = 0; v < 15; v++) begin
      step(tbl[v].re, tbl[v].ra0, tbl[v].ra1, tbl[v].we, tbl[v].wa0, tbl[v].wd0,
           tbl[v].wa1, tbl[v].wd1, tbl[v].al, tbl[v].aa, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d rd_data0", v), bus.rd_data[0 +: XLEN], tbl[v].ed0);
      chk($sformatf("vec%0d rd_data1", v), bus.rd_data[XLEN +: XLEN], tbl[v].ed1);
      chk($sformatf("vec%0d rd_busy", v), 64'(bus.rd_busy), 64'(tbl[v].eb));
      chk($sformatf("vec%0d any_busy", v), 64'(bus.any_busy), 64'(tbl[v].ea));
    end

    // Mid-operation asynchronous reset: build up busy state and data,
    // then pull rst low between edges and expect outputs to clear at once.
    step(2'b11, 5'd3, 5'd5, 2'b01, 5'd3, 64'hCAFE, '0, '0, 1'b1, 5'd3, "pre_rst0");
    step(2'b11, 5'd3, 5'd5, 2'b00, '0, '0, '0, '0, 1'b1, 5'd20, "pre_rst1");
    chk("pre_rst any_busy", 64'(bus.any_busy), 64'h1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    $display("[TB] async_rst -> rd=%h/%h busy=%b any=%b", bus.rd_data[0 +: XLEN],
             bus.rd_data[XLEN +: XLEN], bus.rd_busy, bus.any_busy);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2'b11, 5'd3, 5'd5, 2'b00, '0, '0, '0, '0, 1'b0, '0, "post_rst0");
    chk_all_zero("post_rst0");
    step(2'b11, 5'd20, 5'd9, 2'b00, '0, '0, '0, '0, 1'b0, '0, "post_rst1");
    chk_all_zero("post_rst1");

    // Randomized phase against the reference model; small address pool
    // most of the time to provoke port collisions and bypass hits.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a [6];
      for (int k = 0; k < 6; k++) begin
        a[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                            : AW'($urandom_range(0, 5));
      end
      step(2'($urandom), a[0], a[1], 2'($urandom), a[2], {$urandom, $urandom},
           a[3], {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), a[4],
           $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
